// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default constants for the fetch-stage PC unit
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int PC_ADDR_W    = 16;
    localparam int PC_RESET_VEC = 'h0;
    localparam int PC_EXC_VEC   = 'h8;
    localparam int PC_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count and underflow pulse
module pc_ras
    import pc_pkg::*;
#(
    parameter int RAS_DEPTH = PC_RAS_DEPTH,
    parameter int ADDR_W    = PC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic              has_entry;
    logic              do_push;
    logic              do_pop;
    logic              do_swap;
    logic [PTR_W-1:0]  wr_ptr;

    assign has_entry = (count != '0);
    // call+ret together replaces the top in place; with an empty stack it degrades to a plain push
    assign do_swap   = push & pop & has_entry & ~clear;
    assign do_push   = push & ~do_swap & ~clear;
    assign do_pop    = pop & ~push & has_entry & ~clear;
    assign wr_ptr    = do_swap ? top_ptr : top_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_ptr   <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= pop & ~has_entry & ~clear;
            if (clear) begin
                count <= '0;
            end else if (do_push) begin
                top_ptr <= wr_ptr;
                if (count != FULL) begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_pop) begin
                top_ptr <= top_ptr - PTR_W'(1);
                count   <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push | do_swap) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign top   = mem[top_ptr];
    assign empty = ~has_entry;

endmodule

// File: rtl/if_pc_ctrl.sv
// rtl/if_pc_ctrl.sv - fetch PC register, boot/run/halt FSM and next-pc selection with RAS prediction
module if_pc_ctrl
    import pc_pkg::*;
#(
    parameter int ADDR_W    = PC_ADDR_W,
    parameter int STEP      = 1,
    parameter int RESET_VEC = PC_RESET_VEC,
    parameter int EXC_VEC   = PC_EXC_VEC,
    parameter int RAS_DEPTH = PC_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_i,
    input  logic              stall_i,
    input  logic              rom_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic              call_i,
    input  logic [ADDR_W-1:0] link_addr,
    input  logic              ret_i,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_underflow
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] INC    = ADDR_W'(STEP);

    pc_state_e         state;
    logic              run;
    logic              ret_hit;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] next_pc;

    // a halt request takes precedence over everything else arriving in RUN, so the RAS stays untouched
    assign run     = (state == RUN) & ~halt_i;
    assign ret_hit = ret_i & ~ras_empty;

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (run & call_i),
        .pop       (run & ret_i),
        .clear     (run & exc_valid),
        .push_data (link_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .underflow (ras_underflow)
    );

    always_comb begin
        next_pc = pc;
        if (exc_valid) begin
            next_pc = EXC_PC;
        end else if (br_valid) begin
            next_pc = br_target;
        end else if (ret_hit) begin
            next_pc = ras_top;
        end else if (stall_i | ~rom_ready) begin
            next_pc = pc;
        end else begin
            next_pc = pc + INC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pc    <= RST_PC;
            ce    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    ce    <= 1'b1;
                end
                RUN: begin
                    if (halt_i) begin
                        state <= HALT;
                        ce    <= 1'b0;
                    end else begin
                        pc <= next_pc;
                    end
                end
                HALT: begin
                    if (exc_valid) begin
                        state <= RUN;
                        ce    <= 1'b1;
                        pc    <= EXC_PC;
                    end else if (!halt_i) begin
                        state <= RUN;
                        ce    <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    ce    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_pc_ctrl.sv
// tb/tb_if_pc_ctrl.sv - directed and randomized checks of if_pc_ctrl against a queue-based reference model
module tb_if_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        rom_ready = 1'b1;
    logic        br_valid = 1'b0;
    logic [15:0] br_target = 16'h0;
    logic        exc_valid = 1'b0;
    logic        call_i = 1'b0;
    logic [15:0] link_addr = 16'h0;
    logic        ret_i = 1'b0;
    logic        ce;
    logic [15:0] pc;
    logic        ras_empty;
    logic        ras_underflow;

    int errors = 0;
    int checks = 0;

    // reference model: 0=boot 1=run 2=halt, RAS as a bounded queue (back = most recent)
    int m_state;
    int m_pc;
    bit m_ce;
    bit m_uf;
    int m_ras[$];

    always #5 clk = ~clk;

    if_pc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .halt_i        (halt_i),
        .stall_i       (stall_i),
        .rom_ready     (rom_ready),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .exc_valid     (exc_valid),
        .call_i        (call_i),
        .link_addr     (link_addr),
        .ret_i         (ret_i),
        .ce            (ce),
        .pc            (pc),
        .ras_empty     (ras_empty),
        .ras_underflow (ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_ce    = 1'b0;
        m_uf    = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_update();
        bit have;
        int top;
        m_uf = 1'b0;
        case (m_state)
            0: begin
                m_state = 1;
                m_ce    = 1'b1;
            end
            1: begin
                if (halt_i) begin
                    m_state = 2;
                    m_ce    = 1'b0;
                end else if (exc_valid) begin
                    m_pc = 'h8;
                    m_ras.delete();
                end else begin
                    have = (m_ras.size() > 0);
                    top  = have ? m_ras[$] : 0;
                    if (ret_i && !have) m_uf = 1'b1;
                    if (call_i && ret_i && have) begin
                        m_ras[m_ras.size() - 1] = int'(link_addr);
                    end else begin
                        if (ret_i && have) void'(m_ras.pop_back());
                        if (call_i) begin
                            m_ras.push_back(int'(link_addr));
                            if (m_ras.size() > 4) void'(m_ras.pop_front());
                        end
                    end
                    if (br_valid) m_pc = int'(br_target);
                    else if (ret_i && have) m_pc = top;
                    else if (stall_i || !rom_ready) m_pc = m_pc;
                    else m_pc = (m_pc + 1) % 65536;
                end
            end
            default: begin
                if (exc_valid) begin
                    m_state = 1;
                    m_ce    = 1'b1;
                    m_pc    = 'h8;
                end else if (!halt_i) begin
                    m_state = 1;
                    m_ce    = 1'b1;
                end
            end
        endcase
    endtask

    task automatic compare(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
        chk({tag, "_ce"}, 32'(ce), 32'(m_ce));
        chk({tag, "_empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
        chk({tag, "_uf"}, 32'(ras_underflow), 32'(m_uf));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        compare(tag);
    endtask

    task automatic idle();
        halt_i    = 1'b0;
        stall_i   = 1'b0;
        rom_ready = 1'b1;
        br_valid  = 1'b0;
        exc_valid = 1'b0;
        call_i    = 1'b0;
        ret_i     = 1'b0;
    endtask

    initial begin
        logic [15:0] p;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare("reset");
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_ce", 32'(ce), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step("boot");
        chk("boot_ce", 32'(ce), 32'h1);
        chk("boot_pc", 32'(pc), 32'h0);
        step("run1");
        chk("run1_pc", 32'(pc), 32'h1);

        repeat (4) step("adv");
        chk("at5_pc", 32'(pc), 32'h5);
        stall_i = 1'b1;
        step("stall");
        step("stall");
        chk("stall_pc", 32'(pc), 32'h5);
        stall_i   = 1'b0;
        rom_ready = 1'b0;
        step("notrdy");
        step("notrdy");
        chk("notrdy_pc", 32'(pc), 32'h5);
        rom_ready = 1'b1;

        stall_i   = 1'b1;
        br_valid  = 1'b1;
        br_target = 16'h0040;
        step("br_stall");
        chk("br_stall_pc", 32'(pc), 32'h40);
        exc_valid = 1'b1;
        br_target = 16'h0077;
        step("exc_br");
        chk("exc_br_pc", 32'(pc), 32'h8);
        idle();

        for (int i = 0; i < 5; i++) begin
            call_i    = 1'b1;
            link_addr = 16'(16'h10 + i);
            step("call");
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            ret_i = 1'b1;
            step("ret");
            chk("ret_pc", 32'(pc), 32'(16'h14 - i));
        end
        p = pc;
        step("ret_empty");
        chk("uf_pulse", 32'(ras_underflow), 32'h1);
        chk("uf_pc", 32'(pc), 32'(p + 16'h1));
        idle();
        step("uf_clear");
        chk("uf_drop", 32'(ras_underflow), 32'h0);

        br_valid  = 1'b1;
        br_target = 16'h0020;
        step("to20");
        idle();
        halt_i = 1'b1;
        step("halt");
        chk("halt_ce", 32'(ce), 32'h0);
        chk("halt_pc", 32'(pc), 32'h20);
        step("halt_hold");
        halt_i = 1'b0;
        step("resume");
        chk("resume_ce", 32'(ce), 32'h1);
        chk("resume_pc", 32'(pc), 32'h20);
        step("resume_adv");
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        compare("midrst");
        chk("midrst_pc", 32'(pc), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("reboot");
        step("reboot_run");

        br_valid  = 1'b1;
        br_target = 16'hFFFF;
        step("toffff");
        idle();
        step("wrap");
        chk("wrap_pc", 32'(pc), 32'h0);

        for (int i = 0; i < 400; i++) begin
            halt_i    = ($urandom_range(0, 15) == 0);
            stall_i   = ($urandom_range(0, 3) == 0);
            rom_ready = ($urandom_range(0, 4) != 0);
            br_valid  = ($urandom_range(0, 9) == 0);
            br_target = 16'($urandom);
            exc_valid = ($urandom_range(0, 29) == 0);
            call_i    = ($urandom_range(0, 3) == 0);
            ret_i     = ($urandom_range(0, 3) == 0);
            link_addr = 16'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
